// File: rtl/addsub_cla_pipe_pkg.sv
// Shared types and elaboration helpers for the pipelined carry-lookahead adder-subtractor.
package addsub_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  typedef struct packed {
    logic c;
    logic ovf;
    logic z;
  } flags_t;

  localparam int CLA_GROUP = 4;

  // Legal when the operand splits into whole groups and the groups split evenly across stages.
  function automatic bit stages_legal(input int width, input int group, input int stages);
    if (width <= 0 || group <= 0 || stages <= 0) begin
      return 1'b0;
    end else begin
      return ((width % group) == 0) && (((width / group) % stages) == 0);
    end
  endfunction

endpackage

// File: rtl/addsub_cla_pipe_cla_group.sv
// One 4-bit carry-lookahead group: sum bits plus group propagate/generate for the next level.
module cla_group
  import addsub_pkg::*;
(
  input  logic [CLA_GROUP-1:0] a,
  input  logic [CLA_GROUP-1:0] b,
  input  logic                 cin,
  output logic [CLA_GROUP-1:0] s,
  output logic                 p,
  output logic                 g,
  output logic                 cout
);

  logic [CLA_GROUP-1:0] pb;
  logic [CLA_GROUP-1:0] gb;
  logic [CLA_GROUP-1:0] c;

  always_comb begin
    pb   = a ^ b;
    gb   = a & b;
    c[0] = cin;
    c[1] = gb[0] | (pb[0] & cin);
    c[2] = gb[1] | (pb[1] & gb[0]) | (pb[1] & pb[0] & cin);
    c[3] = gb[2] | (pb[2] & gb[1]) | (pb[2] & pb[1] & gb[0]) | (pb[2] & pb[1] & pb[0] & cin);
    g    = gb[3] | (pb[3] & gb[2]) | (pb[3] & pb[2] & gb[1]) | (pb[3] & pb[2] & pb[1] & gb[0]);
    p    = &pb;
    cout = g | (p & cin);
    s    = pb ^ c;
  end

endmodule

// File: rtl/addsub_cla_pipe.sv
// Pipelined WIDTH-bit adder-subtractor; each stage resolves a slice of CLA groups.
// Optional ADDSUB_SAT_EN adds sat_i and clamps overflowing results.
module addsub_cla_pipe
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int GROUP  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             sub_i,
  input  logic             c_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
`ifdef ADDSUB_SAT_EN
  input  logic             sat_i,
`endif
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] s_o,
  output logic             c_o,
  output logic             ovf_o,
  output logic             z_o
);

  localparam int NGRP = WIDTH / GROUP;
  localparam int GPS  = NGRP / STAGES;
  localparam int NREG = (STAGES > 1) ? STAGES - 1 : 1;
  localparam int L    = STAGES - 1;

  if (!stages_legal(WIDTH, GROUP, STAGES) || GROUP != CLA_GROUP) begin : g_bad_cfg
    $error("addsub_cla_pipe: WIDTH/GROUP/STAGES combination is not supported");
  end

  logic   adv_s;
  logic   accept_s;
  logic   sat_in_s;
  op_e    op_s;

  logic [STAGES-1:0]            st_vld, st_c, st_sat, res_c;
  logic [STAGES-1:0][WIDTH-1:0] st_a, st_bx, st_s, res_s;
  logic [NGRP-1:0][GROUP-1:0]   grp_s;

  logic [NREG-1:0]            vld_q, vld_d, c_q, c_d, sat_q, sat_d;
  logic [NREG-1:0][WIDTH-1:0] a_q, a_d, bx_q, bx_d, s_q, s_d;

  logic             out_vld_q, out_vld_d;
  logic [WIDTH-1:0] out_s_q, out_s_d;
  flags_t           out_f_q, out_f_d;
  logic [WIDTH-1:0] fin_s;
  flags_t           fin_f;

  always_comb begin
    adv_s    = !out_vld_q || ready_i;
    accept_s = valid_i && adv_s;
    op_s     = op_e'(sub_i);
`ifdef ADDSUB_SAT_EN
    sat_in_s = sat_i;
`else
    sat_in_s = 1'b0;
`endif
  end

  // Subtraction is folded in up front: B is inverted and the borrow becomes an inverted carry.
  always_comb begin
    st_vld[0] = accept_s;
    st_a[0]   = a_i;
    st_bx[0]  = (op_s == OP_SUB) ? ~b_i : b_i;
    st_c[0]   = (op_s == OP_SUB) ? !c_i : c_i;
    st_s[0]   = {WIDTH{1'b0}};
    st_sat[0] = sat_in_s;
    for (int k = 1; k < STAGES; k++) begin
      st_vld[k] = vld_q[k-1];
      st_a[k]   = a_q[k-1];
      st_bx[k]  = bx_q[k-1];
      st_s[k]   = s_q[k-1];
      st_c[k]   = c_q[k-1];
      st_sat[k] = sat_q[k-1];
    end
  end

  for (genvar g = 0; g < NGRP; g++) begin : g_grp
    localparam int K = g / GPS;
    logic ci_s, prop_s, gen_s, unused_co_s;

    if ((g % GPS) == 0) begin : g_first
      assign ci_s = st_c[K];
    end else begin : g_next
      assign ci_s = g_grp[g-1].gen_s | (g_grp[g-1].prop_s & g_grp[g-1].ci_s);
    end

    if ((g % GPS) == GPS - 1) begin : g_last
      assign res_c[K] = gen_s | (prop_s & ci_s);
    end

    cla_group u_grp (
      .a    (st_a[K][g*GROUP +: GROUP]),
      .b    (st_bx[K][g*GROUP +: GROUP]),
      .cin  (ci_s),
      .s    (grp_s[g]),
      .p    (prop_s),
      .g    (gen_s),
      .cout (unused_co_s)
    );
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      res_s[k] = st_s[k];
      for (int j = 0; j < GPS; j++) begin
        res_s[k][(k*GPS+j)*GROUP +: GROUP] = grp_s[k*GPS+j];
      end
    end
  end

  always_comb begin
    if (adv_s) begin
      vld_d = vld_q;
      a_d   = a_q;
      bx_d  = bx_q;
      s_d   = s_q;
      c_d   = c_q;
      sat_d = sat_q;
      for (int k = 0; k < STAGES - 1; k++) begin
        vld_d[k] = st_vld[k];
        a_d[k]   = st_a[k];
        bx_d[k]  = st_bx[k];
        s_d[k]   = res_s[k];
        c_d[k]   = res_c[k];
        sat_d[k] = st_sat[k];
      end
    end else begin
      vld_d = vld_q;
      a_d   = a_q;
      bx_d  = bx_q;
      s_d   = s_q;
      c_d   = c_q;
      sat_d = sat_q;
    end
  end

  // On overflow both effective operands share a sign, and that sign is the true result's sign.
  always_comb begin
    fin_f.c   = res_c[L];
    fin_f.ovf = (st_a[L][WIDTH-1] == st_bx[L][WIDTH-1]) &&
                (res_s[L][WIDTH-1] != st_a[L][WIDTH-1]);
    if (st_sat[L] && fin_f.ovf) begin
      fin_s = {st_a[L][WIDTH-1], {(WIDTH-1){~st_a[L][WIDTH-1]}}};
    end else begin
      fin_s = res_s[L];
    end
    fin_f.z = (fin_s == {WIDTH{1'b0}});
  end

  always_comb begin
    if (adv_s) begin
      out_vld_d = st_vld[L];
      if (st_vld[L]) begin
        out_s_d = fin_s;
        out_f_d = fin_f;
      end else begin
        out_s_d = out_s_q;
        out_f_d = out_f_q;
      end
    end else begin
      out_vld_d = out_vld_q;
      out_s_d   = out_s_q;
      out_f_d   = out_f_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q     <= {NREG{1'b0}};
      c_q       <= {NREG{1'b0}};
      sat_q     <= {NREG{1'b0}};
      a_q       <= '0;
      bx_q      <= '0;
      s_q       <= '0;
      out_vld_q <= 1'b0;
      out_s_q   <= {WIDTH{1'b0}};
      out_f_q   <= '0;
    end else begin
      vld_q     <= vld_d;
      c_q       <= c_d;
      sat_q     <= sat_d;
      a_q       <= a_d;
      bx_q      <= bx_d;
      s_q       <= s_d;
      out_vld_q <= out_vld_d;
      out_s_q   <= out_s_d;
      out_f_q   <= out_f_d;
    end
  end

  always_comb begin
    ready_o = adv_s;
    valid_o = out_vld_q;
    s_o     = out_s_q;
    c_o     = out_f_q.c;
    ovf_o   = out_f_q.ovf;
    z_o     = out_f_q.z;
  end

endmodule

// File: tb/tb_addsub_cla_pipe.sv
// Scoreboard bench for addsub_cla_pipe (WIDTH=16, STAGES=2); follows ADDSUB_SAT_EN if defined.
module tb_addsub_cla_pipe;

`ifdef ADDSUB_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        ovf;
    logic        z;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic        sub_i = 1'b0;
  logic        c_i = 1'b0;
  logic [15:0] a_i = 16'h0000;
  logic [15:0] b_i = 16'h0000;
  logic        sat_i = 1'b0;
  logic        valid_o;
  logic        ready_i = 1'b1;
  logic [15:0] s_o;
  logic        c_o;
  logic        ovf_o;
  logic        z_o;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   want_idle = 1'b0;
  bit   final_req = 1'b0;
  bit   stim_done = 1'b0;

  always #5 clk = ~clk;

  addsub_cla_pipe #(.WIDTH(16), .GROUP(4), .STAGES(2)) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .sub_i   (sub_i),
    .c_i     (c_i),
    .a_i     (a_i),
    .b_i     (b_i),
`ifdef ADDSUB_SAT_EN
    .sat_i   (sat_i),
`endif
    .valid_o (valid_o),
    .ready_i (ready_i),
    .s_o     (s_o),
    .c_o     (c_o),
    .ovf_o   (ovf_o),
    .z_o     (z_o)
  );

  // Reference: exact integer arithmetic, then reduce to 16 bits and derive flags.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic sub, input logic cin, input logic sat);
    exp_t e;
    int ua, ub, sa, sb, us, tr;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (!sub) begin
      us  = ua + ub + int'(cin);
      tr  = sa + sb + int'(cin);
      e.c = (us > 65535);
    end else begin
      us  = ua - ub - int'(cin);
      tr  = sa - sb - int'(cin);
      e.c = (us >= 0);
    end
    e.s   = 16'(us);
    e.ovf = (tr > 32767) || (tr < -32768);
    if (SAT_EN && sat && e.ovf) e.s = (tr > 0) ? 16'h7FFF : 16'h8000;
    e.z   = (e.s == 16'h0000);
    e.acc = 0;
    return e;
  endfunction

  // Monitor / scoreboard: owns the expected queue and every comparison.
  initial begin
    int   cyc = 0;
    int   last_stall = -10;
    bit   prev_stall = 1'b0;
    bit   prev_vld = 1'b0;
    bit   prev_xfer = 1'b0;
    logic [15:0] hold_s = 16'h0000;
    logic [2:0]  hold_f = 3'b000;
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_i) begin
        exp_q.delete();
        prev_stall = 1'b0;
        prev_vld   = 1'b0;
        prev_xfer  = 1'b0;
      end else begin
        if (want_idle) begin
          n_cmp++;
          if (valid_o !== 1'b0 || s_o !== 16'h0000 || c_o !== 1'b0 || ovf_o !== 1'b0 ||
              z_o !== 1'b0 || ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL idle_state: got valid=%b s=%h c=%b ovf=%b z=%b ready=%b, want 0 0000 0 0 0 1",
                     valid_o, s_o, c_o, ovf_o, z_o, ready_o);
          end
        end
        n_cmp++;
        if (ready_o !== (!valid_o || ready_i)) begin
          n_err++;
          $display("FAIL ready_rule: got ready_o=%b, want %b (valid_o=%b ready_i=%b)",
                   ready_o, !valid_o || ready_i, valid_o, ready_i);
        end
        if (prev_stall) begin
          n_cmp++;
          if (valid_o !== 1'b1 || s_o !== hold_s || {c_o, ovf_o, z_o} !== hold_f) begin
            n_err++;
            $display("FAIL stall_hold: got valid=%b s=%h flags=%b, want 1 %h %b",
                     valid_o, s_o, {c_o, ovf_o, z_o}, hold_s, hold_f);
          end
        end
        if (valid_o && (!prev_vld || prev_xfer) && exp_q.size() > 0 && last_stall < exp_q[0].acc) begin
          n_cmp++;
          if (cyc != exp_q[0].acc + 2) begin
            n_err++;
            $display("FAIL latency: got %0d cycles, want 2", cyc - exp_q[0].acc);
          end
        end
        if (valid_o && ready_i) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_output: got s=%h with nothing outstanding, want no valid_o", s_o);
          end else begin
            e = exp_q.pop_front();
            if (s_o !== e.s || c_o !== e.c || ovf_o !== e.ovf || z_o !== e.z) begin
              n_err++;
              $display("FAIL result: got s=%h c=%b ovf=%b z=%b, want s=%h c=%b ovf=%b z=%b",
                       s_o, c_o, ovf_o, z_o, e.s, e.c, e.ovf, e.z);
            end
          end
        end
        prev_stall = valid_o && !ready_i;
        if (prev_stall) last_stall = cyc;
        hold_s    = s_o;
        hold_f    = {c_o, ovf_o, z_o};
        prev_vld  = valid_o;
        prev_xfer = valid_o && ready_i;
        if (valid_i && ready_o) begin
          e = model(a_i, b_i, sub_i, c_i, sat_i);
          e.acc = cyc;
          exp_q.push_back(e);
        end
        if (final_req) begin
          n_cmp++;
          if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d results outstanding, want 0", exp_q.size());
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b,
                      input logic sub, input logic cin, input logic sat);
    bit done = 1'b0;
    a_i = a; b_i = b; sub_i = sub; c_i = cin; sat_i = sat; valid_i = 1'b1;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      done = ready_o;
      tick();
    end
    valid_i = 1'b0;
    if (!done) begin
      $display("FAIL send_timeout: got ready_o=0 for 100 cycles, want 1");
      $fatal(1, "input handshake never completed");
    end
  endtask

  function automatic logic [15:0] rnd_op();
    case ($urandom_range(0, 6))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h7FFF;
      3:       return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic check_idle();
    want_idle = 1'b1;
    @(negedge clk);
    #1 want_idle = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of run, want $finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) tick();
    rst_i = 1'b0;
    check_idle();

    // Directed vectors, streamed back to back.
    send(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0);
    send(16'h0005, 16'h0007, 1'b1, 1'b0, 1'b0);
    send(16'h0007, 16'h0005, 1'b1, 1'b0, 1'b0);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
    send(16'h8000, 16'h0001, 1'b1, 1'b0, 1'b1);
    send(16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b0);
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    send(16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0);
    send(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b1);
    repeat (4) tick();

    // Backpressure: 8 ops with ready_i low for cycles 3-6.
    fork
      begin
        for (int c = 0; c < 14; c++) begin
          ready_i = !(c >= 3 && c <= 6);
          tick();
        end
        ready_i = 1'b1;
      end
      begin
        for (int i = 0; i < 8; i++) send(rnd_op(), rnd_op(), 1'($urandom), 1'($urandom), 1'($urandom));
      end
    join
    repeat (4) tick();

    // Reset with two ops in flight and a third offered during reset.
    send(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0);
    send(16'h3333, 16'h0001, 1'b1, 1'b0, 1'b0);
    rst_i = 1'b1; valid_i = 1'b1; a_i = 16'hABCD; b_i = 16'h1234;
    tick();
    rst_i = 1'b0; valid_i = 1'b0;
    check_idle();
    repeat (5) tick();

    // Random streaming with random gaps and random backpressure.
    fork
      begin
        while (!stim_done) begin
          ready_i = ($urandom_range(0, 3) != 0);
          tick();
        end
        ready_i = 1'b1;
      end
      begin
        for (int i = 0; i < 150; i++) begin
          send(rnd_op(), rnd_op(), 1'($urandom), 1'($urandom), 1'($urandom));
          repeat ($urandom_range(0, 2)) tick();
        end
        stim_done = 1'b1;
      end
    join

    ready_i = 1'b1;
    for (int t = 0; t < 50 && exp_q.size() != 0; t++) tick();
    final_req = 1'b1;
    @(negedge clk);
    #1 final_req = 1'b0;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
